// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters feeding decoder_8_3.select.
// The grant is registered and one-hot. It is held until the owner pulses
// done, or until the optional watchdog forces a release. After each release
// the rotating pointer moves to the port just past the owner, which keeps
// access fair between requesters.
module rr_arbiter_8 #(
    parameter int N       = 8,
    parameter int PTR_W   = 3,
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Comparison value for the watchdog. It is clamped to 0 so that the
    // cast stays legal when the watchdog is disabled.
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t           state_reg, state_next;
    logic [N-1:0]     grant_reg, grant_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] owner_idx, owner_nxt;
    logic [TO_W-1:0]  wd_cnt_reg, wd_cnt_next;
    logic             timeout_reg, timeout_next;
    logic             wd_expire;
    logic [N-1:0]     owner_bits [N];

    // Return the first set bit of r, one-hot. The search starts at p and
    // wraps around from N-1 back to 0. The result is 0 when r is 0.
    function automatic logic [N-1:0] pick(input logic [N-1:0] r,
                                          input logic [PTR_W-1:0] p);
        logic [N-1:0] g;
        logic         found;
        int           idx;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(p) + i) % N;
            if (!found && r[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    // Each position contributes its index when it holds the grant.
    // The grant is one-hot, so OR-ing these contributions yields the owner.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_owner
            assign owner_bits[gi] = grant_reg[gi] ? N'(gi) : '0;
        end
    endgenerate

    // Fold the per-port contributions into the owner index.
    always_comb begin
        logic [N-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            acc = acc | owner_bits[i];
        end
        owner_idx = acc[PTR_W-1:0];
    end

    // The next search starts at the port just after the owner.
    assign owner_nxt = (owner_idx == PTR_W'(N - 1)) ? '0 : owner_idx + 1'b1;

    // The watchdog fires on the last permitted cycle of a grant.
    assign wd_expire = (TIMEOUT > 0) && (wd_cnt_reg == TO_W'(TO_LAST));

    // Next-state logic: wait for a request in IDLE. In GRANT, hand off on
    // done or on watchdog expiry. A done in the same cycle as expiry wins,
    // so timeout is not raised in that case.
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        ptr_next     = ptr_reg;
        wd_cnt_next  = wd_cnt_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req != '0) begin
                    grant_next  = pick(req, ptr_reg);
                    state_next  = GRANT;
                    wd_cnt_next = '0;
                end
            end
            GRANT: begin
                if (done || wd_expire) begin
                    ptr_next     = owner_nxt;
                    grant_next   = pick(req, owner_nxt);
                    wd_cnt_next  = '0;
                    timeout_next = !done;
                    if (grant_next == '0) begin
                        state_next = IDLE;
                    end
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State registers. Reset is asynchronous, so a grant is dropped at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            ptr_reg     <= '0;
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            ptr_reg     <= ptr_next;
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign grant       = grant_reg;
    assign grant_valid = (state_reg == GRANT);
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8. One instance has the watchdog disabled.
// A second instance uses TIMEOUT=4 for the watchdog scenario.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant0, grant4;
    logic       grant_valid0, grant_valid4;
    logic       timeout0, timeout4;

    int checks;
    int errors;

    rr_arbiter_8 #(.N(8), .PTR_W(3), .TIMEOUT(0), .TO_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant0), .grant_valid(grant_valid0), .timeout(timeout0)
    );

    rr_arbiter_8 #(.N(8), .PTR_W(3), .TIMEOUT(4), .TO_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant4), .grant_valid(grant_valid4), .timeout(timeout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check the invariants on both instances at every falling edge.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(grant0) || !$onehot0(grant4) ||
            grant_valid0 !== (grant0 != 8'h00) ||
            grant_valid4 !== (grant4 != 8'h00)) begin
            errors++;
            $display("FAIL invariant grant0=%h v0=%b grant4=%h v4=%b",
                     grant0, grant_valid0, grant4, grant_valid4);
        end
    end

    // Stop the run if it overruns its time limit.
    initial begin
        #200000;
        $display("FAIL time_limit exceeded");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        step();
        step();
        checks++;
        if (grant0 !== 8'h00 || grant_valid0 !== 1'b0 || timeout0 !== 1'b0 ||
            grant4 !== 8'h00 || grant_valid4 !== 1'b0 || timeout4 !== 1'b0) begin
            errors++;
            $display("FAIL reset grant=%h valid=%b timeout=%b expected 00/0/0",
                     grant0, grant_valid0, timeout0);
        end
        rst_n = 1'b1;
        step();
        $display("reset: grant=%h valid=%b", grant0, grant_valid0);
    endtask

    task automatic test_basic();
        test_reset();
        req = 8'h81;
        step();
        checks++;
        if (grant0 !== 8'h01 || grant_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_first grant=%h valid=%b expected 01/1", grant0, grant_valid0);
        end
        $display("basic: req=81 grant=%h", grant0);
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant0 !== 8'h80) begin
            errors++;
            $display("FAIL basic_handoff grant=%h expected 80", grant0);
        end
        $display("basic: done grant=%h", grant0);
    endtask

    task automatic test_rotate();
        logic [7:0] exp_seq [9];
        exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        test_reset();
        req = 8'hFF;
        step();
        checks++;
        if (grant0 !== exp_seq[0]) begin
            errors++;
            $display("FAIL rotate_0 grant=%h expected %h", grant0, exp_seq[0]);
        end
        done = 1'b1;
        for (int k = 1; k < 9; k++) begin
            step();
            checks++;
            if (grant0 !== exp_seq[k] || grant_valid0 !== 1'b1) begin
                errors++;
                $display("FAIL rotate_%0d grant=%h expected %h", k, grant0, exp_seq[k]);
            end
            $display("rotate: step %0d grant=%h", k, grant0);
        end
        done = 1'b0;
    endtask

    task automatic test_single_owner();
        test_reset();
        req = 8'h04;
        step();
        done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (grant0 !== 8'h04 || grant_valid0 !== 1'b1) begin
                errors++;
                $display("FAIL single_regrant_%0d grant=%h valid=%b expected 04/1",
                         k, grant0, grant_valid0);
            end
            $display("single: regrant %0d grant=%h", k, grant0);
        end
        // The pointer now sits at 3, so the next handoff should pick port 3.
        req = 8'hFF;
        step();
        done = 1'b0;
        checks++;
        if (grant0 !== 8'h08) begin
            errors++;
            $display("FAIL single_ptr grant=%h expected 08", grant0);
        end
        $display("single: ptr handoff grant=%h", grant0);
    endtask

    task automatic test_hold_release();
        test_reset();
        req = 8'h10;
        step();
        req = 8'h00;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (grant0 !== 8'h10 || grant_valid0 !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d grant=%h expected 10", k, grant0);
            end
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant0 !== 8'h00 || grant_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL release_idle grant=%h valid=%b expected 00/0", grant0, grant_valid0);
        end
        $display("hold: released grant=%h valid=%b", grant0, grant_valid0);
        // A done pulse while idle must be ignored.
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant0 !== 8'h00) begin
            errors++;
            $display("FAIL idle_done grant=%h expected 00", grant0);
        end
        // The pointer moved to 5 when port 4 released.
        req = 8'hFF;
        step();
        checks++;
        if (grant0 !== 8'h20) begin
            errors++;
            $display("FAIL idle_ptr grant=%h expected 20", grant0);
        end
        $display("hold: regrant from idle grant=%h", grant0);
    endtask

    task automatic test_watchdog();
        test_reset();
        req = 8'h02;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (grant4 !== 8'h02 || timeout4 !== 1'b0) begin
                errors++;
                $display("FAIL wd_hold_%0d grant=%h timeout=%b expected 02/0", k, grant4, timeout4);
            end
        end
        step();
        checks++;
        if (grant4 !== 8'h02 || timeout4 !== 1'b1 || grant_valid4 !== 1'b1) begin
            errors++;
            $display("FAIL wd_expire grant=%h timeout=%b expected 02/1", grant4, timeout4);
        end
        $display("watchdog: expiry grant=%h timeout=%b", grant4, timeout4);
        step();
        checks++;
        if (timeout4 !== 1'b0) begin
            errors++;
            $display("FAIL wd_pulse_width timeout=%b expected 0", timeout4);
        end
        step();
        step();
        // done coincides with expiry: it counts as a plain done.
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant4 !== 8'h02 || timeout4 !== 1'b0) begin
            errors++;
            $display("FAIL wd_done_wins grant=%h timeout=%b expected 02/0", grant4, timeout4);
        end
        checks++;
        if (grant0 !== 8'h02 || timeout0 !== 1'b0) begin
            errors++;
            $display("FAIL wd_disabled grant=%h timeout=%b expected 02/0", grant0, timeout0);
        end
        $display("watchdog: done at expiry grant=%h timeout=%b", grant4, timeout4);
    endtask

    task automatic test_async_reset();
        test_reset();
        req = 8'hFF;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant0 !== 8'h00 || grant_valid0 !== 1'b0 || grant4 !== 8'h00) begin
            errors++;
            $display("FAIL async_reset grant=%h valid=%b expected 00/0", grant0, grant_valid0);
        end
        $display("async reset: grant=%h", grant0);
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (grant0 !== 8'h01 || grant_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL after_reset grant=%h expected 01", grant0);
        end
        $display("async reset: regrant grant=%h", grant0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        done   = 1'b0;
        test_reset();
        test_basic();
        test_rotate();
        test_single_owner();
        test_hold_release();
        test_watchdog();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
